// File: rtl/hazard_control_unit_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding, the
// bundle of pipeline control strobes, and the canned strobe patterns.
package hazard_control_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } hcu_state_e;

  localparam int unsigned MEM_TIMEOUT_DEFAULT = 15;

  typedef struct packed {
    logic pcWe;
    logic ifIdWe;
    logic idExWe;
    logic exMemWe;
    logic ifIdFlush;
    logic idExFlush;
    logic memWbBubble;
  } hcu_ctrl_t;

  localparam hcu_ctrl_t CTRL_OFF = '{default: 1'b0};

  // Whole pipeline held while memory is outstanding; MEM/WB gets a NOP.
  localparam hcu_ctrl_t CTRL_FREEZE = '{pcWe: 1'b0, ifIdWe: 1'b0, idExWe: 1'b0,
                                        exMemWe: 1'b0, ifIdFlush: 1'b0,
                                        idExFlush: 1'b0, memWbBubble: 1'b1};

  localparam hcu_ctrl_t CTRL_BRANCH = '{pcWe: 1'b1, ifIdWe: 1'b1, idExWe: 1'b1,
                                        exMemWe: 1'b1, ifIdFlush: 1'b1,
                                        idExFlush: 1'b1, memWbBubble: 1'b0};

  localparam hcu_ctrl_t CTRL_LOAD_USE = '{pcWe: 1'b0, ifIdWe: 1'b0, idExWe: 1'b1,
                                          exMemWe: 1'b1, ifIdFlush: 1'b0,
                                          idExFlush: 1'b1, memWbBubble: 1'b0};

  localparam hcu_ctrl_t CTRL_NORMAL = '{pcWe: 1'b1, ifIdWe: 1'b1, idExWe: 1'b1,
                                        exMemWe: 1'b1, ifIdFlush: 1'b0,
                                        idExFlush: 1'b0, memWbBubble: 1'b0};

  // Control for a cycle where memory is not holding the pipeline.
  function automatic hcu_ctrl_t flowCtrl(input logic branchTaken, input logic loadUse);
    if (branchTaken) return CTRL_BRANCH;
    else if (loadUse) return CTRL_LOAD_USE;
    else return CTRL_NORMAL;
  endfunction

endpackage

// File: rtl/hazard_control_unit_sat_counter16.sv
// 16-bit up counter with synchronous clear (dominant over increment) that
// sticks at all-ones instead of wrapping.
module sat_counter16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_inc,
  output logic [15:0] o_count
);

  logic [15:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != 16'hFFFF)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stalls, branch flushes, data-memory
// wait freezing with a timeout that latches a sticky fault.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  IF_ID_rs,
  input  logic [4:0]  IF_ID_rt,
  input  logic        IF_ID_uses_rs,
  input  logic        IF_ID_uses_rt,
  input  logic        ID_EX_mem_read,
  input  logic [4:0]  ID_EX_rd,
  input  logic        branch_taken,
  input  logic        EX_MEM_mem_req,
  input  logic        mem_ack,
  input  logic        stall_count_clr,
  output logic        pc_write_enable,
  output logic        IF_ID_write_enable,
  output logic        ID_EX_write_enable,
  output logic        EX_MEM_write_enable,
  output logic        IF_ID_flush,
  output logic        ID_EX_flush,
  output logic        MEM_WB_bubble,
  output logic        mem_fault,
  output logic [15:0] stall_count
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  hcu_state_e r_state;
  logic [7:0] r_waitCnt;
  logic       r_memFault;
  logic       w_memBusy;
  logic       w_loadUse;
  logic       w_stallInc;
  hcu_ctrl_t  w_ctrl;

  assign w_memBusy = EX_MEM_mem_req & ~mem_ack;
  assign w_loadUse = ID_EX_mem_read && (ID_EX_rd != 5'd0) &&
                     ((IF_ID_uses_rs && (ID_EX_rd == IF_ID_rs)) ||
                      (IF_ID_uses_rt && (ID_EX_rd == IF_ID_rt)));

  // Strobes act in the same cycle; reset forces every strobe low.
  always_comb begin
    w_ctrl = CTRL_FREEZE;
    case (r_state)
      ST_RUN:      w_ctrl = w_memBusy ? CTRL_FREEZE : flowCtrl(branch_taken, w_loadUse);
      ST_MEM_WAIT: w_ctrl = mem_ack ? flowCtrl(branch_taken, w_loadUse) : CTRL_FREEZE;
      ST_FAULT:    w_ctrl = CTRL_FREEZE;
      default:     w_ctrl = CTRL_FREEZE;
    endcase
    if (!rst_n) w_ctrl = CTRL_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_waitCnt  <= '0;
      r_memFault <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_memBusy) begin
            r_state   <= ST_MEM_WAIT;
            r_waitCnt <= 8'd1;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ack) begin
            r_state   <= ST_RUN;
            r_waitCnt <= '0;
          end else if (r_waitCnt == TIMEOUT_CNT) begin
            r_state    <= ST_FAULT;
            r_memFault <= 1'b1;
          end else begin
            r_waitCnt <= r_waitCnt + 8'd1;
          end
        end
        ST_FAULT: r_memFault <= 1'b1;
        default: begin
          r_state   <= ST_RUN;
          r_waitCnt <= '0;
        end
      endcase
    end
  end

  // A faulted pipeline is dead, so its frozen cycles are not stalls.
  assign w_stallInc = ~w_ctrl.pcWe & (r_state != ST_FAULT);

  sat_counter16 u_stallCounter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (stall_count_clr),
    .i_inc   (w_stallInc),
    .o_count (stall_count)
  );

  assign pc_write_enable     = w_ctrl.pcWe;
  assign IF_ID_write_enable  = w_ctrl.ifIdWe;
  assign ID_EX_write_enable  = w_ctrl.idExWe;
  assign EX_MEM_write_enable = w_ctrl.exMemWe;
  assign IF_ID_flush         = w_ctrl.ifIdFlush;
  assign ID_EX_flush         = w_ctrl.idExFlush;
  assign MEM_WB_bubble       = w_ctrl.memWbBubble;
  assign mem_fault           = r_memFault;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed vector table,
// multi-cycle memory/timeout/saturation sequences, and a randomized run.
module tb_hazard_control_unit;

   localparam int unsigned TIMEOUT = 4;

   localparam logic [6:0] C_OFF      = 7'b0000_000;
   localparam logic [6:0] C_NORMAL   = 7'b1111_000;
   localparam logic [6:0] C_LOADUSE  = 7'b0011_010;
   localparam logic [6:0] C_BRANCH   = 7'b1111_110;
   localparam logic [6:0] C_FROZEN   = 7'b0000_001;

   typedef struct {
      logic [4:0] rs;
      logic [4:0] rt;
      logic       usesRs;
      logic       usesRt;
      logic       memRead;
      logic [4:0] rd;
      logic       branch;
      logic       req;
      logic       ack;
      logic       clr;
   } stim_t;

   typedef struct {
      stim_t      stim;
      logic [6:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  IF_ID_rs = '0, IF_ID_rt = '0, ID_EX_rd = '0;
   logic        IF_ID_uses_rs = 1'b0, IF_ID_uses_rt = 1'b0, ID_EX_mem_read = 1'b0;
   logic        branch_taken = 1'b0, EX_MEM_mem_req = 1'b0, mem_ack = 1'b0;
   logic        stall_count_clr = 1'b0;
   logic        pc_write_enable, IF_ID_write_enable, ID_EX_write_enable, EX_MEM_write_enable;
   logic        IF_ID_flush, ID_EX_flush, MEM_WB_bubble, mem_fault;
   logic [15:0] stall_count;
   logic [6:0]  dutCtrl;

   int nChecks = 0;
   int nPass = 0;

   always #5 clk = ~clk;

   assign dutCtrl = {pc_write_enable, IF_ID_write_enable, ID_EX_write_enable,
                     EX_MEM_write_enable, IF_ID_flush, ID_EX_flush, MEM_WB_bubble};

   hazard_control_unit #(.MEM_TIMEOUT(TIMEOUT)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .IF_ID_rs            (IF_ID_rs),
      .IF_ID_rt            (IF_ID_rt),
      .IF_ID_uses_rs       (IF_ID_uses_rs),
      .IF_ID_uses_rt       (IF_ID_uses_rt),
      .ID_EX_mem_read      (ID_EX_mem_read),
      .ID_EX_rd            (ID_EX_rd),
      .branch_taken        (branch_taken),
      .EX_MEM_mem_req      (EX_MEM_mem_req),
      .mem_ack             (mem_ack),
      .stall_count_clr     (stall_count_clr),
      .pc_write_enable     (pc_write_enable),
      .IF_ID_write_enable  (IF_ID_write_enable),
      .ID_EX_write_enable  (ID_EX_write_enable),
      .EX_MEM_write_enable (EX_MEM_write_enable),
      .IF_ID_flush         (IF_ID_flush),
      .ID_EX_flush         (ID_EX_flush),
      .MEM_WB_bubble       (MEM_WB_bubble),
      .mem_fault           (mem_fault),
      .stall_count         (stall_count)
   );

   function automatic stim_t mkStim(input logic [4:0] rs, input logic [4:0] rt,
                                    input logic usesRs, input logic usesRt,
                                    input logic memRead, input logic [4:0] rd,
                                    input logic branch, input logic req, input logic ack);
      stim_t s;
      s.rs = rs; s.rt = rt; s.usesRs = usesRs; s.usesRt = usesRt;
      s.memRead = memRead; s.rd = rd; s.branch = branch;
      s.req = req; s.ack = ack; s.clr = 1'b0;
      return s;
   endfunction

   // Drives one set of pipeline conditions onto the DUT inputs.
   task automatic applyStimulus(input stim_t s);
      IF_ID_rs        = s.rs;
      IF_ID_rt        = s.rt;
      IF_ID_uses_rs   = s.usesRs;
      IF_ID_uses_rt   = s.usesRt;
      ID_EX_mem_read  = s.memRead;
      ID_EX_rd        = s.rd;
      branch_taken    = s.branch;
      EX_MEM_mem_req  = s.req;
      mem_ack         = s.ack;
      stall_count_clr = s.clr;
   endtask

   // Compares one observed value against the bench's expectation.
   task automatic checkOutput(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
      nChecks++;
      if (actual !== expected)
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      else
         nPass++;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Holds reset for one full clock, optionally checking the reset values.
   task automatic doReset(input bit doCheck);
      nextCycle();
      rst_n = 1'b0;
      applyStimulus(mkStim(5, 5, 1, 1, 1, 5, 1, 1, 0));
      @(negedge clk);
      if (doCheck) begin
         checkOutput("resetCtrl", {9'd0, dutCtrl}, {9'd0, C_OFF});
         checkOutput("resetStall", stall_count, 16'd0);
         checkOutput("resetFault", {15'd0, mem_fault}, 16'd0);
      end
      nextCycle();
      applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0));
      rst_n = 1'b1;
   endtask

   vec_t vecs[11];

   // Reference model state, kept as spec-level quantities.
   bit mFault;
   int mFrozenRun;
   int mStall;

   initial begin
      stim_t s;
      logic [6:0] expC;
      bit busy, lu;

      vecs[0]  = '{stim: mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0), exp: C_NORMAL};
      vecs[1]  = '{stim: mkStim(5, 0, 1, 0, 1, 5, 0, 0, 0), exp: C_LOADUSE};
      vecs[2]  = '{stim: mkStim(0, 0, 1, 0, 1, 0, 0, 0, 0), exp: C_NORMAL};
      vecs[3]  = '{stim: mkStim(1, 7, 0, 1, 1, 7, 0, 0, 0), exp: C_LOADUSE};
      vecs[4]  = '{stim: mkStim(5, 0, 0, 0, 1, 5, 0, 0, 0), exp: C_NORMAL};
      vecs[5]  = '{stim: mkStim(5, 0, 1, 0, 1, 5, 1, 0, 0), exp: C_BRANCH};
      vecs[6]  = '{stim: mkStim(0, 0, 0, 0, 0, 0, 1, 1, 0), exp: C_FROZEN};
      vecs[7]  = '{stim: mkStim(5, 0, 1, 0, 1, 5, 0, 1, 1), exp: C_LOADUSE};
      vecs[8]  = '{stim: mkStim(0, 0, 0, 0, 0, 0, 0, 0, 1), exp: C_NORMAL};
      vecs[9]  = '{stim: mkStim(3, 3, 1, 1, 0, 3, 0, 0, 0), exp: C_NORMAL};
      vecs[10] = '{stim: mkStim(2, 9, 1, 1, 1, 9, 0, 1, 0), exp: C_FROZEN};

      $display("[TB] reset checks");
      doReset(1);

      $display("[TB] vector table");
      for (int i = 0; i < 11; i++) begin
         doReset(0);
         applyStimulus(vecs[i].stim);
         @(negedge clk);
         checkOutput($sformatf("vec%0d", i), {9'd0, dutCtrl}, {9'd0, vecs[i].exp});
      end

      $display("[TB] single load-use stall");
      doReset(0);
      applyStimulus(mkStim(5, 0, 1, 0, 1, 5, 0, 0, 0));
      @(negedge clk);
      checkOutput("luStallCtrl", {9'd0, dutCtrl}, {9'd0, C_LOADUSE});
      nextCycle();
      applyStimulus(mkStim(5, 0, 1, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      checkOutput("luAfterCtrl", {9'd0, dutCtrl}, {9'd0, C_NORMAL});
      checkOutput("luStallCount", stall_count, 16'd1);

      $display("[TB] three-cycle memory wait");
      doReset(0);
      applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0, 1, 0));
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput($sformatf("waitFrozen%0d", k), {9'd0, dutCtrl}, {9'd0, C_FROZEN});
         checkOutput($sformatf("waitStall%0d", k), stall_count, 16'(k));
         nextCycle();
      end
      mem_ack = 1'b1;
      @(negedge clk);
      checkOutput("waitRelease", {9'd0, dutCtrl}, {9'd0, C_NORMAL});
      checkOutput("waitStallTotal", stall_count, 16'd3);
      nextCycle();
      applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      checkOutput("waitBackInRun", {9'd0, dutCtrl}, {9'd0, C_NORMAL});
      checkOutput("waitNoFault", {15'd0, mem_fault}, 16'd0);

      $display("[TB] memory timeout");
      doReset(0);
      applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0, 1, 0));
      for (int k = 0; k <= int'(TIMEOUT); k++) begin
         @(negedge clk);
         checkOutput($sformatf("toPreFault%0d", k), {15'd0, mem_fault}, 16'd0);
         nextCycle();
      end
      @(negedge clk);
      checkOutput("toFaultSet", {15'd0, mem_fault}, 16'd1);
      checkOutput("toFrozen", {9'd0, dutCtrl}, {9'd0, C_FROZEN});
      checkOutput("toStallAtFault", stall_count, 16'(TIMEOUT + 1));
      nextCycle();
      applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 1, 1, 1));
      @(negedge clk);
      checkOutput("toAbsorbing", {9'd0, dutCtrl}, {9'd0, C_FROZEN});
      checkOutput("toStallHeld", stall_count, 16'(TIMEOUT + 1));
      nextCycle();
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("toResetFault", {15'd0, mem_fault}, 16'd0);
      nextCycle();
      rst_n = 1'b1;
      applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      checkOutput("toRecovered", {9'd0, dutCtrl}, {9'd0, C_NORMAL});
      checkOutput("toStallCleared", stall_count, 16'd0);

      $display("[TB] stall counter saturation");
      doReset(0);
      applyStimulus(mkStim(5, 0, 1, 0, 1, 5, 0, 0, 0));
      for (int k = 0; k < 65534; k++) @(posedge clk);
      @(negedge clk);
      checkOutput("satNearTop", stall_count, 16'hFFFE);
      for (int k = 0; k < 6; k++) @(posedge clk);
      @(negedge clk);
      checkOutput("satTop", stall_count, 16'hFFFF);
      nextCycle();
      stall_count_clr = 1'b1;
      @(negedge clk);
      checkOutput("satBeforeClr", stall_count, 16'hFFFF);
      nextCycle();
      stall_count_clr = 1'b0;
      @(negedge clk);
      checkOutput("satCleared", stall_count, 16'd0);

      $display("[TB] randomized run");
      doReset(0);
      mFault = 0;
      mFrozenRun = 0;
      mStall = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         s.rs      = 5'($urandom_range(0, 3));
         s.rt      = 5'($urandom_range(0, 3));
         s.usesRs  = 1'($urandom_range(0, 1));
         s.usesRt  = 1'($urandom_range(0, 1));
         s.memRead = 1'($urandom_range(0, 1));
         s.rd      = 5'($urandom_range(0, 3));
         s.branch  = ($urandom_range(0, 99) < 20);
         s.req     = ($urandom_range(0, 99) < 30);
         s.ack     = ($urandom_range(0, 99) < 55);
         s.clr     = ($urandom_range(0, 99) < 3);
         applyStimulus(s);
         rst_n = ($urandom_range(0, 99) >= 2);

         lu = s.memRead && (s.rd != 0) &&
              ((s.usesRs && s.rd == s.rs) || (s.usesRt && s.rd == s.rt));
         if (!rst_n) begin
            mFault = 0;
            mFrozenRun = 0;
            mStall = 0;
            expC = C_OFF;
            busy = 0;
         end else begin
            busy = (mFrozenRun == 0) ? (s.req && !s.ack) : !s.ack;
            if (mFault || busy) expC = C_FROZEN;
            else if (s.branch) expC = C_BRANCH;
            else if (lu) expC = C_LOADUSE;
            else expC = C_NORMAL;
         end

         @(negedge clk);
         checkOutput($sformatf("rndCtrl%0d", cyc), {9'd0, dutCtrl}, {9'd0, expC});
         checkOutput($sformatf("rndStall%0d", cyc), stall_count, 16'(mStall));
         checkOutput($sformatf("rndFault%0d", cyc), {15'd0, mem_fault}, {15'd0, mFault});

         if (rst_n) begin
            if (s.clr) mStall = 0;
            else if (!mFault && !expC[6] && mStall < 65535) mStall++;
            if (!mFault) begin
               if (busy) begin
                  if (mFrozenRun == int'(TIMEOUT)) mFault = 1;
                  else mFrozenRun++;
               end else begin
                  mFrozenRun = 0;
               end
            end
         end
         nextCycle();
      end

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
